spi_host_ctrl: RTL and testbench
================================

// Module: spi_host_ctrl
// PURPOSE
//  SPI mode-0 controller (host end) for the shapool device SPI ports: drives sck/cs_n/mosi, samples miso.
//  Shifts out a DATA_WIDTH-bit word MSB-first and simultaneously captures DATA_WIDTH bits.
//  Used by the host/test FPGA to load job config (SPI0), load or chain device config and read results (SPI1).
//  The target samples on synchronized sck rising edges, so this block runs sck at a divided rate.
// PARAMETERS
//  DATA_WIDTH  32  bits per transfer; must be >= 2.
//  CLK_DIV     4   sck half-period in clk cycles; must be >= 4 so the target's 3-stage sck sync and sdo update settle.
// PORTS
//  clk       in   1           core clock
//  reset_n   in   1           synchronous, active-low reset
//  start     in   1           1-cycle request; sampled only in IDLE
//  tx_data   in   DATA_WIDTH  word to send; captured on the accepted start
//  busy      out  1           high from the cycle after an accepted start until done
//  done      out  1           1-cycle pulse; rx_data valid in the same cycle
//  rx_data   out  DATA_WIDTH  captured miso word; holds its value until the next done
//  sck       out  1           SPI clock, idle low
//  mosi      out  1           to target sdi
//  miso      in   1           from target sdo
//  cs_n      out  1           chip select, active low
// BEHAVIOUR
//  Reset values: sck=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, state=IDLE.
//  Reset mid-transfer: next edge forces all reset values. No partial rx_data update. No done pulse.
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
//   IDLE:  on start: load shift_reg=tx_data, cs_n<=0, mosi<=tx_data[MSB], busy<=1, go to SETUP.
//   SETUP: wait CLK_DIV cycles with sck=0. Then go to SHIFT.
//   SHIFT: toggle sck every CLK_DIV cycles, for 2*DATA_WIDTH toggles.
//     Rising edge: sample miso into shift_reg LSB (shift left).
//     Falling edge: mosi<=next bit. No mosi update after the last falling edge.
//   HOLD:  sck=0, cs_n=0 for CLK_DIV cycles. Then cs_n<=1.
//   DONE:  done=1 and rx_data<=shift_reg for one cycle. busy<=0. Go to IDLE.
//  Latency: done is asserted exactly 1+(2*DATA_WIDTH+2)*CLK_DIV cycles after the accepted start cycle.
//  start while busy or in DONE: ignored, not queued.
//  start in the same cycle as done: ignored. A new start is accepted from the next cycle.
//  Bit counter and divider counter are $clog2-sized. Divider wraps at CLK_DIV-1.
//  Bit counter saturates; it never wraps into a 2nd word.
//  Elaboration error if DATA_WIDTH<2 or CLK_DIV<4.
// CONFIGURATION
//  Macro SPI_HOST_CTRL_BURST_EN:
//   Defined: adds input hold_cs (1 bit), sampled at HOLD entry.
//     If hold_cs=1: cs_n stays 0 through DONE and IDLE.
//     The next accepted start skips SETUP; its first rising edge comes CLK_DIV cycles after start.
//     cs_n deasserts only after a transfer that ends with hold_cs=0, or on reset.
//     Used to clock result/config chains longer than DATA_WIDTH through daisy-chained devices.
//   Undefined: no hold_cs port. Every transfer is framed by its own cs_n low/high.
// STRUCTURE
//  Shared package shapool_spi_pkg holds:
//   the state encoding localparams (IDLE/SETUP/SHIFT/HOLD/DONE, 3 bits);
//   SPI mode constant (CPOL=0, CPHA=0);
//   MIN_CLK_DIV=4, shared with external_io documentation.
//  One sub-module, spi_sck_gen: divider counter and sck output.
//   Emits 1-cycle rise_tick/fall_tick strobes and is enabled by the FSM.
//  Shift register and FSM stay in spi_host_ctrl.
// TESTING
//  Loopback (miso=mosi), DATA_WIDTH=8, CLK_DIV=4, tx 0xA5:
//   -> exactly 8 sck rises; rx_data=0xA5; done 73 cycles after start; cs_n high before done.
//  Target model returns 0x3C, tx 0xFF:
//   -> rx_data=0x3C; mosi stays 1 across all 8 bits; mosi changes only while sck low.
//  start held high for 200 cycles:
//   -> exactly two transfers; the second start is accepted the cycle after done.
//   -> busy low exactly 1 cycle between the transfers.
//  reset_n low at the 4th sck rise:
//   -> next cycle sck=0, cs_n=1, busy=0; no done pulse; rx_data keeps its prior value.
//  SPI_HOST_CTRL_BURST_EN, two transfers with hold_cs=1 then 0, tx 0x12 then 0x34:
//   -> cs_n low continuously across both transfers; 16 sck rises total; mosi stream 0x1234.
//  Against the shapool SPI slave (DEVICE_CONFIG_WIDTH=8) in IDLE, tx 0x5A, then tx 0x00:
//   -> the slave's device config register reads 0x5A; rx_data on the 2nd transfer = 0x5A.

Source files
------------

// File: rtl/shapool_spi_pkg.sv
// Shared definitions for the shapool SPI host: FSM state encoding, SPI mode
// constants and the minimum sck half-period.
package shapool_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } spi_state_t;

   // Mode 0: sck idles low, data sampled on the rising edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   // The target needs 3 clocks to synchronise sck plus one to update sdo.
   localparam int MIN_CLK_DIV = 4;

endpackage

// File: rtl/spi_sck_gen.sv
// sck divider for the SPI host: counts CLK_DIV-cycle periods while enabled and
// toggles sck at each period end when sck_en is set, emitting edge strobes.
module spi_sck_gen
   import shapool_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic sck_en,
   output logic tick,
   output logic rise_tick,
   output logic fall_tick,
   output logic sck
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_reg;
   logic             sck_reg;

   always_ff @(posedge clk) begin
      if (!reset_n || !en) begin
         div_reg <= '0;
      end else if (div_reg == DIV_LAST) begin
         div_reg <= '0;
      end else begin
         div_reg <= div_reg + DIV_W'(1);
      end
   end

   // The edge that ends a period also flips sck, so the strobes mark the edge itself.
   always_ff @(posedge clk) begin
      if (!reset_n || !sck_en) begin
         sck_reg <= SPI_CPOL;
      end else if (tick) begin
         sck_reg <= ~sck_reg;
      end
   end

   assign tick      = en && (div_reg == DIV_LAST);
   assign rise_tick = tick && sck_en && (sck_reg == SPI_CPOL);
   assign fall_tick = tick && sck_en && (sck_reg != SPI_CPOL);
   assign sck       = sck_reg;

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI mode-0 host: shifts a DATA_WIDTH word out on mosi MSB-first while capturing miso.
// Optional SPI_HOST_CTRL_BURST_EN adds hold_cs to keep cs_n low across transfers.
module spi_host_ctrl
   import shapool_spi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
`ifdef SPI_HOST_CTRL_BURST_EN
   input  logic                  hold_cs,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  sck,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  cs_n
);

   generate
      if (DATA_WIDTH < 2 || CLK_DIV < MIN_CLK_DIV) begin : g_param_check
         $error("spi_host_ctrl: DATA_WIDTH must be >= 2 and CLK_DIV >= %0d", MIN_CLK_DIV);
      end
   endgenerate

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH);

   spi_state_t state_reg, state_next;

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] rx_reg;
   logic [CNT_W-1:0]      fall_cnt_reg;
   logic                  mosi_reg;
   logic                  cs_n_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  hold_reg;
   logic                  skip_setup;
   logic                  last_fall;
   logic                  div_en;
   logic                  sck_en;
   logic                  tick;
   logic                  rise_tick;
   logic                  fall_tick;

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (div_en),
      .sck_en    (sck_en),
      .tick      (tick),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .sck       (sck)
   );

   assign last_fall = (fall_cnt_reg == CNT_LAST);

`ifdef SPI_HOST_CTRL_BURST_EN
   // hold_cs is latched on the last falling edge, i.e. as HOLD is entered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_reg <= 1'b0;
      end else if (state_reg == ST_SHIFT && fall_tick && last_fall) begin
         hold_reg <= hold_cs;
      end
   end
   // cs_n still low in IDLE means the previous transfer asked to keep the frame open.
   assign skip_setup = !cs_n_reg;
`else
   assign hold_reg   = 1'b0;
   assign skip_setup = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      div_en     = 1'b0;
      sck_en     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = skip_setup ? ST_SHIFT : ST_SETUP;
            end
         end
         ST_SETUP: begin
            div_en = 1'b1;
            if (tick) state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            div_en = 1'b1;
            sck_en = 1'b1;
            if (fall_tick && last_fall) state_next = ST_HOLD;
         end
         ST_HOLD: begin
            div_en = 1'b1;
            if (tick) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift_reg    <= '0;
         rx_reg       <= '0;
         fall_cnt_reg <= '0;
         mosi_reg     <= 1'b0;
         cs_n_reg     <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  shift_reg    <= tx_data;
                  mosi_reg     <= tx_data[DATA_WIDTH-1];
                  cs_n_reg     <= 1'b0;
                  busy_reg     <= 1'b1;
                  fall_cnt_reg <= '0;
               end
            end
            ST_SHIFT: begin
               if (rise_tick) begin
                  shift_reg <= {shift_reg[DATA_WIDTH-2:0], miso};
               end
               if (fall_tick) begin
                  if (fall_cnt_reg != CNT_MAX) fall_cnt_reg <= fall_cnt_reg + CNT_W'(1);
                  // After the final fall the MSB holds received data, not a bit to send.
                  if (!last_fall) mosi_reg <= shift_reg[DATA_WIDTH-1];
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  cs_n_reg <= !hold_reg;
                  rx_reg   <= shift_reg;
                  done_reg <= 1'b1;
               end
            end
            ST_DONE: busy_reg <= 1'b0;
            default: ;
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign rx_data = rx_reg;
   assign mosi    = mosi_reg;
   assign cs_n    = cs_n_reg;

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Self-checking bench for spi_host_ctrl (DATA_WIDTH=8, CLK_DIV=4) with a behavioural
// SPI target; define SPI_HOST_CTRL_BURST_EN to also exercise the hold_cs burst.
module tb_spi_host_ctrl;

   localparam int DW = 8;
   localparam int CD = 4;

   typedef struct {
      logic [7:0] rx;
      int         lat;
      int         rises;
      int         chg;
      int         cs_hi;
      logic       cs_done;
      bit         ok;
   } xfer_res_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          busy, done, sck, mosi, miso, cs_n;
   logic [DW-1:0] rx_data;
`ifdef SPI_HOST_CTRL_BURST_EN
   logic          hold_cs = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Target model state; counters only grow, the main thread takes snapshots.
   int          rise_total = 0, fall_total = 0, mosi_chg = 0, viol_total = 0;
   int          fall_base = 0;
   logic        sck_q = 1'b0, mosi_q = 1'b0;
   logic [31:0] slave_sr = '0;
   logic [7:0]  resp_word = '0;
   bit          loop_mode = 1'b1;
   logic        resp_bit;

   always #5 clk = ~clk;

   spi_host_ctrl #(
      .DATA_WIDTH (DW),
      .CLK_DIV    (CD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .tx_data (tx_data),
`ifdef SPI_HOST_CTRL_BURST_EN
      .hold_cs (hold_cs),
`endif
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .sck     (sck),
      .mosi    (mosi),
      .miso    (miso),
      .cs_n    (cs_n)
   );

   // The target presents response bit k after the k-th falling edge of the word.
   always_comb begin
      resp_bit = 1'b0;
      if (fall_total - fall_base < 8) resp_bit = resp_word[3'(7 - (fall_total - fall_base))];
   end
   assign miso = loop_mode ? mosi : resp_bit;

   always @(negedge clk) begin
      if (sck && !sck_q) begin
         rise_total = rise_total + 1;
         slave_sr   = {slave_sr[30:0], mosi};
      end
      if (!sck && sck_q) fall_total = fall_total + 1;
      if (mosi !== mosi_q) begin
         mosi_chg = mosi_chg + 1;
         if (sck && sck_q) viol_total = viol_total + 1;
      end
      sck_q  = sck;
      mosi_q = mosi;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input bit skip);
      return 1 + (2 * DW + (skip ? 1 : 2)) * CD;
   endfunction

   // Starts at a negedge, returns at the negedge where done is high.
   task automatic do_xfer(input logic [7:0] tx, input logic [7:0] resp, input bit loop,
                          input int start_hold, output xfer_res_t r);
      int rise_base, chg_base;
      rise_base = rise_total;
      fall_base = fall_total;
      chg_base  = mosi_chg;
      resp_word = resp;
      loop_mode = loop;
      tx_data   = tx;
      start     = 1'b1;
      r.lat = 0; r.ok = 1'b0; r.cs_hi = 0;
      while (r.lat < 400) begin
         @(negedge clk);
         r.lat++;
         if (r.lat == 2) chg_base = mosi_chg;
         if (r.lat >= start_hold) start = 1'b0;
         if (done) begin
            r.ok = 1'b1;
            break;
         end
         if (cs_n) r.cs_hi++;
      end
      start     = 1'b0;
      r.rx      = rx_data;
      r.cs_done = cs_n;
      r.rises   = rise_total - rise_base;
      r.chg     = mosi_chg - chg_base;
      $display("[TB] xfer tx=%02h resp=%02h loop=%0d rx=%02h lat=%0d rises=%0d",
               tx, resp, loop, r.rx, r.lat, r.rises);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      xfer_res_t  r, r2;
      logic [7:0] tx, resp;
      bit         lp;
      int         n, nd, d1, d2, blow;

      repeat (3) @(negedge clk);
      check_eq("rst_sck",  sck, 0);
      check_eq("rst_cs_n", cs_n, 1);
      check_eq("rst_mosi", mosi, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rx",   rx_data, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset at the 4th sck rise of the first transfer: rx_data still holds its (reset) value.
      fall_base = fall_total;
      n = rise_total;
      loop_mode = 1'b1; tx_data = 8'hC3; start = 1'b1;
      nd = 0;
      while (rise_total - n < 4 && nd < 200) begin
         @(negedge clk);
         nd++;
         start = 1'b0;
      end
      check_eq("midrst_reach_rise4", nd < 200, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check_eq("midrst_sck",  sck, 0);
      check_eq("midrst_cs_n", cs_n, 1);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_rx",   rx_data, 0);
      reset_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check_eq("midrst_no_done", nd, 0);
      $display("[TB] mid-transfer reset at rise 4, done pulses after=%0d", nd);

      // Loopback 0xA5.
      do_xfer(8'hA5, 8'h00, 1'b1, 1, r);
      check_eq("lb_ok",    r.ok, 1);
      check_eq("lb_rx",    r.rx, 8'hA5);
      check_eq("lb_lat",   r.lat, exp_lat(1'b0));
      check_eq("lb_rises", r.rises, DW);
      check_eq("lb_cs_n",  r.cs_done, 1);
      check_eq("lb_slave", slave_sr[7:0], 8'hA5);
      @(negedge clk);
      check_eq("lb_busy_after", busy, 0);

      // Target returns 0x3C while host sends all ones.
      do_xfer(8'hFF, 8'h3C, 1'b0, 1, r);
      check_eq("ff_rx",        r.rx, 8'h3C);
      check_eq("ff_mosi_flat", r.chg, 0);
      check_eq("ff_slave",     slave_sr[7:0], 8'hFF);
      @(negedge clk);

      // Random transfers; start may stay high well into the transfer and must be ignored.
      for (int k = 0; k < 16; k++) begin
         tx   = 8'($urandom);
         resp = 8'($urandom);
         lp   = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         do_xfer(tx, resp, lp, $urandom_range(1, 40), r);
         check_eq("rnd_ok",    r.ok, 1);
         check_eq("rnd_rx",    r.rx, lp ? tx : resp);
         check_eq("rnd_lat",   r.lat, exp_lat(1'b0));
         check_eq("rnd_rises", r.rises, DW);
         check_eq("rnd_slave", slave_sr[7:0], tx);
         check_eq("rnd_cs_lo", r.cs_hi, 0);
         check_eq("rnd_cs_n",  r.cs_done, 1);
         @(negedge clk);
         check_eq("rnd_idle",  busy, 0);
      end
      check_eq("mosi_stable_while_sck_high", viol_total, 0);

      // start held for 200 cycles.
      loop_mode = 1'b1; fall_base = fall_total; tx_data = 8'h69; start = 1'b1;
      nd = 0; d1 = -1; d2 = -1; blow = 0;
      for (int s = 1; s < 200; s++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (d1 < 0) d1 = s;
            else if (d2 < 0) d2 = s;
         end else if (d1 >= 0 && d2 < 0 && !busy) begin
            blow++;
         end
      end
      start = 1'b0;
      $display("[TB] held start: done pulses=%0d at %0d and %0d, busy-low gap=%0d", nd, d1, d2, blow);
      check_eq("held_done_cnt", nd, 2);
      check_eq("held_first",    d1, exp_lat(1'b0));
      check_eq("held_gap",      d2 - d1, exp_lat(1'b0) + 1);
      check_eq("held_busy_low", blow, 1);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("held_drain", done, 1);
      @(negedge clk);

`ifdef SPI_HOST_CTRL_BURST_EN
      n = rise_total;
      hold_cs = 1'b1;
      do_xfer(8'h12, 8'h00, 1'b1, 1, r);
      check_eq("burst1_cs_n", r.cs_done, 0);
      check_eq("burst1_lat",  r.lat, exp_lat(1'b0));
      @(negedge clk);
      check_eq("burst_gap_cs_n", cs_n, 0);
      hold_cs = 1'b0;
      do_xfer(8'h34, 8'h00, 1'b1, 1, r2);
      check_eq("burst2_lat",   r2.lat, exp_lat(1'b1));
      check_eq("burst2_cs_lo", r2.cs_hi, 0);
      check_eq("burst2_cs_n",  r2.cs_done, 1);
      check_eq("burst_rises",  rise_total - n, 2 * DW);
      check_eq("burst_stream", slave_sr[15:0], 16'h1234);
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
